// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared types, constants and helpers for the SIPO frame deserializer
package sipo_pkg;

  localparam int OVF_CNT_W = 16;
  localparam int MAX_WIDTH = 255;
  localparam int MAX_CW    = 4;

  function automatic int chan_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  // Widest legal entry; the top narrows data/chan to its own WIDTH/CW
  typedef struct packed {
    logic [MAX_WIDTH-1:0] data;
    logic [MAX_CW-1:0]    chan;
  } word_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO, power-of-two depth, push accepted when full if a pop coincides
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Storage is cleared on reset so the head reads zero out of reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/sipo_frame_deserializer.sv
// rtl/sipo_frame_deserializer.sv - serial-to-parallel audio word assembler with frame sync and output FIFO
// Optional SIPO_OVF_COUNT_EN adds a saturating dropped-word counter port ovf_count.
module sipo_frame_deserializer import sipo_pkg::*; #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 4,
  localparam int CW      = chan_w(CHANNELS)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in,
  input  logic                 enable,
  input  logic                 frame,
  input  logic                 msb_first,
  output logic [WIDTH-1:0]     out_data,
  output logic [CW-1:0]        out_chan,
  output logic                 out_valid,
  input  logic                 out_ready,
`ifdef SIPO_OVF_COUNT_EN
  output logic [OVF_CNT_W-1:0] ovf_count,
`endif
  output logic                 overflow,
  output logic                 sync_err
);

  localparam int            BW        = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_CHAN = CW'(CHANNELS - 1);

  logic [BW-1:0]    bit_cnt;
  logic [CW-1:0]    chan_cnt;
  logic [WIDTH-1:0] shreg;
  logic             msb_q;

  logic             resync;
  logic [BW-1:0]    bit_idx;
  logic [CW-1:0]    chan_idx;
  logic             word_start;
  logic             msb_mode;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] shreg_next;
  logic             last_bit;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic             drop;

  // A frame marker forces this bit to be bit 0 of channel 0, discarding any partial word
  always_comb begin
    resync     = frame && ((bit_cnt != '0) || (chan_cnt != '0));
    bit_idx    = frame ? '0 : bit_cnt;
    chan_idx   = frame ? '0 : chan_cnt;
    word_start = (bit_idx == '0);
    msb_mode   = word_start ? msb_first : msb_q;
    base       = word_start ? '0 : shreg;
    shreg_next = msb_mode ? {base[WIDTH-2:0], in} : {in, base[WIDTH-1:1]};
    last_bit   = (bit_idx == LAST_BIT);
    push       = enable && last_bit;
  end

  assign pop       = out_valid && out_ready;
  assign out_valid = !empty;
  assign drop      = push && full && !pop;

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     (WIDTH + CW)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .push_data ({shreg_next, chan_idx}),
    .pop       (pop),
    .pop_data  ({out_data, out_chan}),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      bit_cnt  <= '0;
      chan_cnt <= '0;
      shreg    <= '0;
      msb_q    <= 1'b0;
      overflow <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      overflow <= drop;
      sync_err <= enable && resync;
      if (enable) begin
        shreg <= shreg_next;
        msb_q <= msb_mode;
        if (last_bit) begin
          bit_cnt  <= '0;
          chan_cnt <= (chan_idx == LAST_CHAN) ? '0 : chan_idx + CW'(1);
        end else begin
          bit_cnt  <= bit_idx + BW'(1);
          chan_cnt <= chan_idx;
        end
      end
    end
  end

`ifdef SIPO_OVF_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rstn)
      ovf_count <= '0;
    else if (drop && (ovf_count != '1))
      ovf_count <= ovf_count + OVF_CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_sipo_frame_deserializer.sv
// tb/tb_sipo_frame_deserializer.sv - directed self-checking bench for sipo_frame_deserializer (WIDTH=8, CHANNELS=2, DEPTH=4)
module tb_sipo_frame_deserializer;

  logic       clk = 1'b0;
  logic       rstn;
  logic       in;
  logic       enable;
  logic       frame;
  logic       msb_first;
  logic       out_ready;
  logic [7:0] out_data;
  logic [0:0] out_chan;
  logic       out_valid;
  logic       overflow;
  logic       sync_err;
`ifdef SIPO_OVF_COUNT_EN
  logic [15:0] ovf_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sipo_frame_deserializer #(
    .WIDTH    (8),
    .CHANNELS (2),
    .DEPTH    (4)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in        (in),
    .enable    (enable),
    .frame     (frame),
    .msb_first (msb_first),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef SIPO_OVF_COUNT_EN
    .ovf_count (ovf_count),
`endif
    .overflow  (overflow),
    .sync_err  (sync_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic fr, input logic msb);
    in        = b;
    frame     = fr;
    msb_first = msb;
    enable    = 1'b1;
    tick();
  endtask

  task automatic send_word(input logic [7:0] d, input logic msb);
    for (int i = 0; i < 8; i++) send_bit(msb ? d[7-i] : d[i], 1'b0, msb);
  endtask

  task automatic idle();
    enable = 1'b0;
    frame  = 1'b0;
    tick();
  endtask

  task automatic check_head(input string tag, input logic [7:0] d, input logic c);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"},  32'(out_data),  32'(d));
    check({tag, "_chan"},  32'(out_chan),  32'(c));
  endtask

  initial begin
    logic [7:0] w;
    rstn = 1'b0; in = 1'b0; enable = 1'b0; frame = 1'b0; msb_first = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  32'(out_data),  32'd0);
    check("rst_chan",  32'(out_chan),  32'd0);
    check("rst_ovf",   32'(overflow),  32'd0);
    check("rst_sync",  32'(sync_err),  32'd0);
`ifdef SIPO_OVF_COUNT_EN
    check("rst_ovfcnt", 32'(ovf_count), 32'd0);
`endif
    rstn = 1'b1;
    out_ready = 1'b1;

    // LSB-first words, no frame marker needed after reset
    w = 8'hA5;
    for (int i = 0; i < 7; i++) send_bit(w[i], 1'b0, 1'b0);
    check("lsb_a5_pre_valid", 32'(out_valid), 32'd0);
    send_bit(w[7], 1'b0, 1'b0);
    check_head("lsb_a5", 8'hA5, 1'b0);
    w = 8'h3C;
    send_bit(w[0], 1'b0, 1'b0);
    check("lsb_popped", 32'(out_valid), 32'd0);
    for (int i = 1; i < 8; i++) send_bit(w[i], 1'b0, 1'b0);
    check_head("lsb_3c", 8'h3C, 1'b1);

    // MSB first, msb_first dropped after bit 2 must not alter the word
    w = 8'hA5;
    for (int i = 0; i < 8; i++) send_bit(w[7-i], 1'b0, (i < 3));
    check_head("msb_a5", 8'hA5, 1'b0);

    // Channel 1 filler, then 3 bits of channel 0 and a mid-frame marker
    send_word(8'h00, 1'b0);
    check_head("fill_00", 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 1'b0);
    check("partial_no_valid", 32'(out_valid), 32'd0);
    check("partial_no_sync", 32'(sync_err), 32'd0);
    w = 8'h5A;
    send_bit(w[0], 1'b1, 1'b0);
    check("sync_pulse", 32'(sync_err), 32'd1);
    send_bit(w[1], 1'b0, 1'b0);
    check("sync_clear", 32'(sync_err), 32'd0);
    for (int i = 2; i < 8; i++) send_bit(w[i], 1'b0, 1'b0);
    check_head("resync_5a", 8'h5A, 1'b0);
    idle();
    check("drain_5a", 32'(out_valid), 32'd0);

    // Stall: six words into a four-deep FIFO
    out_ready = 1'b0;
    send_word(8'h11, 1'b0);
    check_head("stall_w1", 8'h11, 1'b1);
    send_word(8'h22, 1'b0);
    send_word(8'h33, 1'b0);
    send_word(8'h44, 1'b0);
    check_head("stall_w4", 8'h11, 1'b1);
    check("stall_w4_ovf", 32'(overflow), 32'd0);
    send_word(8'h55, 1'b0);
    check("ovf_pulse1", 32'(overflow), 32'd1);
    check_head("stall_w5", 8'h11, 1'b1);
    send_bit(1'b0, 1'b0, 1'b0);
    check("ovf_clear1", 32'(overflow), 32'd0);
    for (int i = 1; i < 8; i++) send_bit(1'b0, 1'b0, 1'b0);
    check("ovf_pulse2", 32'(overflow), 32'd1);
    idle();
    check("ovf_clear2", 32'(overflow), 32'd0);
    check_head("stall_w6", 8'h11, 1'b1);
`ifdef SIPO_OVF_COUNT_EN
    check("ovfcnt_2", 32'(ovf_count), 32'd2);
`endif
    out_ready = 1'b1;
    check_head("drain_11", 8'h11, 1'b1); tick();
    check_head("drain_22", 8'h22, 1'b0); tick();
    check_head("drain_33", 8'h33, 1'b1); tick();
    check_head("drain_44", 8'h44, 1'b0); tick();
    check("drain_empty", 32'(out_valid), 32'd0);

    // Full FIFO with a pop coinciding with the fifth push
    out_ready = 1'b0;
    send_word(8'h01, 1'b0);
    send_word(8'h02, 1'b0);
    send_word(8'h03, 1'b0);
    send_word(8'h04, 1'b0);
    w = 8'h05;
    for (int i = 0; i < 7; i++) send_bit(w[i], 1'b0, 1'b0);
    out_ready = 1'b1;
    send_bit(w[7], 1'b0, 1'b0);
    out_ready = 1'b0;
    check("coinc_no_ovf", 32'(overflow), 32'd0);
    check_head("coinc_head", 8'h02, 1'b0);
    send_word(8'h06, 1'b0);
    check("coinc_still_full", 32'(overflow), 32'd1);
`ifdef SIPO_OVF_COUNT_EN
    check("ovfcnt_3", 32'(ovf_count), 32'd3);
`endif
    enable = 1'b0;
    out_ready = 1'b1;
    check_head("coinc_02", 8'h02, 1'b0); tick();
    check_head("coinc_03", 8'h03, 1'b1); tick();
    check_head("coinc_04", 8'h04, 1'b0); tick();
    check_head("coinc_05", 8'h05, 1'b1); tick();
    check("coinc_empty", 32'(out_valid), 32'd0);

    // Reset mid-word with two words queued; enable held high during reset
    out_ready = 1'b0;
    send_word(8'h77, 1'b0);
    send_word(8'h88, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, 1'b0);
    rstn = 1'b0;
    send_bit(1'b1, 1'b1, 1'b1);
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_data",  32'(out_data),  32'd0);
    check("mrst_chan",  32'(out_chan),  32'd0);
    check("mrst_ovf",   32'(overflow),  32'd0);
    check("mrst_sync",  32'(sync_err),  32'd0);
`ifdef SIPO_OVF_COUNT_EN
    check("mrst_ovfcnt", 32'(ovf_count), 32'd0);
`endif
    rstn = 1'b1;
    out_ready = 1'b1;
    send_word(8'hC3, 1'b0);
    check_head("post_rst_c3", 8'hC3, 1'b0);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
